// File: rtl/paddle_ctrl.sv
// paddle_ctrl: paddle y from synchronized up/down buttons, speed ramp, playfield clamp.
// Optional AI_TRACK_EN: with ai_en=1 the paddle tracks ball_y outside a deadband.
module paddle_ctrl #(
    parameter int POS_X      = 20,
    parameter int POS_Y      = 245,
    parameter int PADDLE_H   = 60,
    parameter int Y_MIN      = 35,
    parameter int Y_MAX      = 515,
    parameter int HOLD_TICKS = 8,
    parameter int MAX_SPEED  = 6,
    parameter int DEADBAND   = 4
) (
    input  logic       game_clk,
    input  logic       rst,
    input  logic       btn_up,
    input  logic       btn_down,
    input  logic       ai_en,
    input  logic [9:0] ball_y,
    output logic [9:0] x,
    output logic [9:0] y,
    output logic [3:0] speed
);

    localparam int HOLD_W = (HOLD_TICKS > 1) ? $clog2(HOLD_TICKS) : 1;
    localparam logic signed [10:0] Y_LO = 11'(Y_MIN);
    localparam logic signed [10:0] Y_HI = 11'(Y_MAX - PADDLE_H);

    typedef enum logic [1:0] {
        IDLE,
        MOVE_UP,
        MOVE_DOWN
    } state_t;

    state_t              state;
    state_t              state_next;
    state_t              req;
    state_t              btn_req;
    logic [1:0]          up_sync;
    logic [1:0]          down_sync;
    logic                up_s;
    logic                down_s;
    logic [HOLD_W-1:0]   hold;
    logic [HOLD_W-1:0]   hold_next;
    logic [3:0]          speed_next;
    logic signed [10:0]  y_sum;
    logic [9:0]          y_next;

    assign up_s   = up_sync[1];
    assign down_s = down_sync[1];

    always_comb begin
        btn_req = IDLE;
        unique case (1'b1)
            up_s && !down_s: btn_req = MOVE_UP;
            down_s && !up_s: btn_req = MOVE_DOWN;
            default:         btn_req = IDLE;
        endcase
    end

`ifdef AI_TRACK_EN
    logic [9:0]  ball_q;
    logic [10:0] ai_center;
    state_t      ai_req;

    always_ff @(posedge game_clk) begin
        if (rst) ball_q <= '0;
        else     ball_q <= ball_y;
    end

    always_comb begin
        ai_center = {1'b0, y} + 11'(PADDLE_H / 2);
        ai_req    = IDLE;
        if (({1'b0, ball_q} + 11'(DEADBAND)) < ai_center)
            ai_req = MOVE_UP;
        else if ({1'b0, ball_q} > (ai_center + 11'(DEADBAND)))
            ai_req = MOVE_DOWN;
    end

    assign req = ai_en ? ai_req : btn_req;
`else
    logic unused_ai;
    assign unused_ai = ^{ai_en, ball_y};
    assign req = btn_req;
`endif

    // Same direction ramps speed every HOLD_TICKS ticks; anything else restarts at 1.
    always_comb begin
        state_next = IDLE;
        speed_next = 4'd0;
        hold_next  = '0;
        if (req != IDLE) begin
            state_next = req;
            speed_next = 4'd1;
            if (req == state) begin
                speed_next = speed;
                hold_next  = hold + HOLD_W'(1);
                if (hold == HOLD_W'(HOLD_TICKS - 1)) begin
                    hold_next = '0;
                    if (speed < 4'(MAX_SPEED))
                        speed_next = speed + 4'd1;
                end
            end
        end
    end

    always_comb begin
        unique case (state)
            MOVE_UP:   y_sum = signed'({1'b0, y}) - signed'({7'b0, speed});
            MOVE_DOWN: y_sum = signed'({1'b0, y}) + signed'({7'b0, speed});
            default:   y_sum = signed'({1'b0, y});
        endcase
        if (y_sum < Y_LO)
            y_next = 10'(Y_MIN);
        else if (y_sum > Y_HI)
            y_next = 10'(Y_MAX - PADDLE_H);
        else
            y_next = y_sum[9:0];
    end

    always_ff @(posedge game_clk) begin
        if (rst) begin
            up_sync   <= '0;
            down_sync <= '0;
            state     <= IDLE;
            speed     <= 4'd0;
            hold      <= '0;
            x         <= 10'(POS_X);
            y         <= 10'(POS_Y);
        end else begin
            up_sync   <= {up_sync[0], btn_up};
            down_sync <= {down_sync[0], btn_down};
            state     <= state_next;
            speed     <= speed_next;
            hold      <= hold_next;
            y         <= y_next;
        end
    end

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb_paddle_ctrl: run-length speed model checked every cycle plus directed literals.
// Define AI_TRACK_EN to also exercise ball tracking.
module tb_paddle_ctrl;

    logic       game_clk = 1'b0;
    logic       rst      = 1'b1;
    logic       btn_up   = 1'b0;
    logic       btn_down = 1'b0;
    logic       ai_en    = 1'b0;
    logic [9:0] ball_y   = 10'd0;
    logic [9:0] x;
    logic [9:0] y;
    logic [3:0] speed;

    int n_tests = 0;
    int n_fail  = 0;
    bit chk_en  = 0;

    paddle_ctrl dut (
        .game_clk(game_clk),
        .rst     (rst),
        .btn_up  (btn_up),
        .btn_down(btn_down),
        .ai_en   (ai_en),
        .ball_y  (ball_y),
        .x       (x),
        .y       (y),
        .speed   (speed)
    );

    always #5 game_clk = ~game_clk;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Model: direction seen two ticks late, speed from how long it has persisted.
    int m_y   = 245;
    int m_dir = 0;
    int m_run = 0;
    int m_spd = 0;
    int m_ball = 0;
    bit up_d[2];
    bit dn_d[2];

    always @(posedge game_clk) begin
        int req;
        int ctr;
        if (rst) begin
            m_y = 245; m_dir = 0; m_run = 0; m_spd = 0; m_ball = 0;
            up_d[0] = 0; up_d[1] = 0; dn_d[0] = 0; dn_d[1] = 0;
        end else begin
            req = 0;
            if (up_d[1] && !dn_d[1]) req = -1;
            if (dn_d[1] && !up_d[1]) req = 1;
`ifdef AI_TRACK_EN
            if (ai_en) begin
                ctr = m_y + 30;
                req = 0;
                if (m_ball + 4 < ctr) req = -1;
                else if (m_ball > ctr + 4) req = 1;
            end
`endif
            m_y = m_y + m_dir * m_spd;
            if (m_y < 35) m_y = 35;
            if (m_y > 455) m_y = 455;
            if (req == 0) m_run = 0;
            else if (req == m_dir) m_run++;
            else m_run = 1;
            m_dir = req;
            m_spd = (m_run == 0) ? 0 : 1 + (m_run - 1) / 8;
            if (m_spd > 6) m_spd = 6;
            up_d[1] = up_d[0]; up_d[0] = btn_up;
            dn_d[1] = dn_d[0]; dn_d[0] = btn_down;
            m_ball = int'(ball_y);
        end
    end

    always @(negedge game_clk) begin
        if (chk_en) begin
            check("x", int'(x), 20);
            check("y", int'(y), m_y);
            check("speed", int'(speed), m_spd);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge game_clk);
        @(negedge game_clk);
    endtask

    initial begin
        @(negedge game_clk);
        tick(2);
        chk_en = 1;
        rst = 1'b0;
        tick(50);
        check("reset_x", int'(x), 20);
        check("reset_y", int'(y), 245);
        check("reset_speed", int'(speed), 0);

        btn_down = 1'b1;
        tick(3);
        check("ramp_e3_y", int'(y), 245);
        check("ramp_e3_speed", int'(speed), 1);
        tick(1);
        check("ramp_e4_y", int'(y), 246);
        tick(6);
        check("ramp_e10_speed", int'(speed), 1);
        tick(1);
        check("ramp_e11_speed", int'(speed), 2);
        check("ramp_e11_y", int'(y), 253);
        tick(100);
        check("bottom_y", int'(y), 455);
        check("bottom_speed", int'(speed), 6);

        btn_up = 1'b1;
        tick(3);
        check("both_speed", int'(speed), 0);
        check("both_y", int'(y), 455);
        tick(10);
        check("both_hold_y", int'(y), 455);
        btn_up = 1'b0;
        btn_down = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;

        btn_up = 1'b1;
        tick(120);
        check("top_reach_y", int'(y), 35);
        btn_up = 1'b0;
        tick(5);
        btn_down = 1'b1;
        tick(5);
        btn_down = 1'b0;
        tick(6);
        check("tap_y40", int'(y), 40);
        btn_up = 1'b1;
        tick(3);
        check("top_e3_y", int'(y), 40);
        for (int i = 0; i < 5; i++) begin
            tick(1);
            check("top_step_y", int'(y), 39 - i);
        end
        tick(30);
        check("top_clamp_y", int'(y), 35);
        check("top_clamp_speed", int'(speed), 5);

        btn_up = 1'b0;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        btn_up = 1'b1;
        tick(27);
        check("rev_pre_y", int'(y), 197);
        check("rev_pre_speed", int'(speed), 4);
        btn_up = 1'b0;
        btn_down = 1'b1;
        tick(3);
        check("rev_speed", int'(speed), 1);
        check("rev_y", int'(y), 185);
        tick(1);
        check("rev_step_y", int'(y), 186);
        tick(20);
        rst = 1'b1;
        tick(1);
        check("midrst_y", int'(y), 245);
        check("midrst_speed", int'(speed), 0);
        rst = 1'b0;
        tick(10);
        btn_down = 1'b0;
        tick(5);

`ifdef AI_TRACK_EN
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        ai_en = 1'b1;
        ball_y = 10'd400;
        for (int i = 0; i < 300; i++) begin
            btn_up = (i % 3) == 0;
            btn_down = (i % 5) == 1;
            tick(1);
        end
        check("ai_down_settle", int'((int'(y) + 30 - 400) <= 4 && (400 - int'(y) - 30) <= 4), 1);
        ball_y = 10'd100;
        for (int i = 0; i < 300; i++) begin
            btn_up = (i % 4) == 2;
            btn_down = (i % 2) == 0;
            tick(1);
        end
        check("ai_up_settle", int'((int'(y) + 30 - 100) <= 4 && (100 - int'(y) - 30) <= 4), 1);
        btn_up = 1'b0;
        btn_down = 1'b0;
        ai_en = 1'b0;
        tick(5);
`endif

        chk_en = 0;
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/paddle_ctrl.md
Name: paddle_ctrl

Overview:
- Produces one paddle's position (x, y) from up/down player buttons, one update per game_clk tick.
- Its x/y outputs feed the ball's p1_x/p1_y or p2_x/p2_y inputs and the renderer; ball_y is fed back from the ball for the optional auto-track mode.
- Speed ramps with hold time; the paddle is clamped to the playfield.

Parameters:
- POS_X, 20: fixed paddle x (left edge); never changes.
- POS_Y, 245: reset y (top edge of paddle).
- PADDLE_H, 60: paddle height in pixels.
- Y_MIN, 35: top playfield limit; minimum legal y.
- Y_MAX, 515: bottom playfield limit; maximum legal y is Y_MAX-PADDLE_H.
- HOLD_TICKS, 8: ticks of continuous same-direction movement per speed increment.
- MAX_SPEED, 6: speed ceiling in pixels/tick (range 1..15).
- DEADBAND, 4: auto-track dead zone in pixels (optional feature only).

Ports:
- game_clk, input, 1: game tick clock.
- rst, input, 1: synchronous active-high reset.
- btn_up, input, 1: move-up request, asynchronous to game_clk.
- btn_down, input, 1: move-down request, asynchronous to game_clk.
- ai_en, input, 1: auto-track select; ignored unless AI_TRACK_EN is defined.
- ball_y, input, 10: ball top-edge y; used only by auto-track.
- x, output, 10: paddle x, constant POS_X.
- y, output, 10: paddle top-edge y.
- speed, output, 4: current step size; 0 when not moving.

Behaviour:
- Reset: rst synchronous, active-high; clock game_clk. On any game_clk edge with rst=1: x=POS_X, y=POS_Y, speed=0, state=IDLE, hold counter=0, synchronizer flops=0. Reset mid-move takes priority over everything else.
- Input sync: btn_up and btn_down each pass through a 2-flop synchronizer, giving up_s and down_s.
- Request decode: up_s&!down_s gives UP; down_s&!up_s gives DOWN; otherwise NONE. Both pressed is NONE.
- FSM states: IDLE, MOVE_UP, MOVE_DOWN, registered from the decoded request.
  - Any state with request NONE goes to IDLE; speed=0 and hold=0.
  - IDLE with UP/DOWN goes to MOVE_UP/MOVE_DOWN; speed=1, hold=0.
  - Same direction held: hold increments. When hold reaches HOLD_TICKS-1, hold=0 and speed=min(speed+1, MAX_SPEED).
  - Direction reversal (MOVE_UP and DOWN, or the inverse): go directly to the opposite state; speed=1, hold=0.
- Position update: each edge, using the registered state and speed from the previous cycle:
  - MOVE_UP: y_next = y - speed.
  - MOVE_DOWN: y_next = y + speed.
  - IDLE: y holds.
- Width and clamping:
  - Arithmetic is done in 11-bit signed so no wrap-around occurs.
  - If the result < Y_MIN, y=Y_MIN. If > Y_MAX-PADDLE_H, y=Y_MAX-PADDLE_H.
  - At a limit, state and speed continue to evolve; y just stays clamped.
- Latency: button asserted before edge 1 gives state MOVE at edge 3 and the first y change at edge 4.
- x is a constant register and never changes outside reset.

Optional Feature:
- Macro: AI_TRACK_EN.
- Defined, ai_en=1:
  - Buttons are ignored.
  - center = y + PADDLE_H/2.
  - Request is UP if ball_y + DEADBAND < center, DOWN if ball_y > center + DEADBAND, otherwise NONE.
  - ball_y is registered once before the compare, adding 1 cycle of latency, no synchronizer.
  - FSM, ramp and clamping are identical to button mode.
- Defined, ai_en=0: button mode.
- Undefined: ai_en and ball_y are ignored; button mode always; no comparator logic.

Test Plan:
- Reset, defaults: rst=1 for 2 ticks, then release with no buttons -> x=20, y=245, speed=0, stable for 50 ticks.
- Ramp: hold btn_down from y=245 -> y first changes at edge 4 to 246. Speed becomes 2 after 8 ticks of MOVE, reaches 6, and never exceeds 6.
- Top clamp: hold btn_up from y=40 -> y steps 39, 38, ... and stops at 35. It remains 35 while held; speed keeps ramping.
- Bottom clamp and both buttons:
  - Hold btn_down -> y saturates at 455.
  - Press both -> state IDLE, speed=0, y frozen at 455.
- Reversal and reset mid-move:
  - At speed 4 moving up, switch to btn_down -> speed=1 and y increases by 1 on the next update.
  - Assert rst during a move -> y=245 and speed=0 on that same edge.
- AI tracking (AI_TRACK_EN): ai_en=1, y=245, ball_y=400 -> paddle moves down until center is within 4 of 400. Then ball_y=100 -> paddle moves up; buttons toggled throughout have no effect.
